// File: rtl/dac_serializer.sv
// Two-lane serial DAC driver on the 8-bit peripheral bus: shadow-buffered MSB-first
// shift of two samples against a divided serial clock, then a latch-enable pulse.
module dac_serializer #(
  parameter int DATA_W = 16,
  parameter int DIV_W  = 8
) (
  input  logic       clk_i,
  input  logic       rst_n,
  input  logic [3:0] addr,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  input  logic       bus_cyc,
  input  logic       bus_we,
  output logic       irq,
  output logic       DAC_clk,
  output logic       DAC_le,
  output logic       DAC_d1,
  output logic       DAC_d2
);
  localparam int          BC_W     = $clog2(DATA_W);
  localparam logic [15:0] STG_MASK = 16'((32'd1 << DATA_W) - 32'd1);

  typedef enum logic [1:0] {IDLE, SHIFT_LO, SHIFT_HI, LATCH} state_t;

  state_t            state, state_nx;
  logic [DIV_W-1:0]  div, cnt, cnt_nx;
  logic [BC_W-1:0]   bcnt, bcnt_nx;
  logic [15:0]       cha, chb, cha_nx, chb_nx;
  logic [DATA_W-1:0] sha, shb;
  logic              auto_en, ie, pend, pend_nx, done;
  logic              wr, trig, w1c, load, shift, done_set, phase_end;
  logic [7:0]        rd_mux;

  assign wr        = bus_cyc & bus_we;
  assign trig      = wr & (((addr == 4'd5) & data_in[0]) | ((addr == 4'd3) & auto_en));
  assign w1c       = wr & (addr == 4'd6) & data_in[7];
  assign phase_end = (cnt == '0);

  // Staging after this cycle's write, so an AUTO trigger on CHB_H ships the new byte.
  always_comb begin
    cha_nx = cha;
    chb_nx = chb;
    if (wr) begin
      case (addr)
        4'd0: cha_nx[7:0]  = data_in;
        4'd1: cha_nx[15:8] = data_in;
        4'd2: chb_nx[7:0]  = data_in;
        4'd3: chb_nx[15:8] = data_in;
        default: ;
      endcase
    end
    cha_nx = cha_nx & STG_MASK;
    chb_nx = chb_nx & STG_MASK;
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Half-period counter reloads from DIV only at phase boundaries.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    bcnt_nx  = bcnt;
    pend_nx  = pend;
    load     = 1'b0;
    shift    = 1'b0;
    done_set = 1'b0;
    case (state)
      IDLE: if (trig) begin
        state_nx = SHIFT_LO;
        cnt_nx   = div;
        bcnt_nx  = BC_W'(DATA_W - 1);
        load     = 1'b1;
      end
      SHIFT_LO: begin
        if (phase_end) begin
          state_nx = SHIFT_HI;
          cnt_nx   = div;
        end else cnt_nx = cnt - 1'b1;
      end
      SHIFT_HI: begin
        if (phase_end) begin
          cnt_nx = div;
          if (bcnt != '0) begin
            shift    = 1'b1;
            bcnt_nx  = bcnt - 1'b1;
            state_nx = SHIFT_LO;
          end else state_nx = LATCH;
        end else cnt_nx = cnt - 1'b1;
      end
      LATCH: begin
        if (phase_end) begin
          done_set = 1'b1;
          if (pend | trig) begin
            pend_nx  = 1'b0;
            load     = 1'b1;
            state_nx = SHIFT_LO;
            cnt_nx   = div;
            bcnt_nx  = BC_W'(DATA_W - 1);
          end else state_nx = IDLE;
        end else cnt_nx = cnt - 1'b1;
      end
      default: state_nx = IDLE;
    endcase
    if (trig && state != IDLE && !(state == LATCH && phase_end)) pend_nx = 1'b1;
  end

  always_comb begin
    case (addr)
      4'd0:    rd_mux = cha[7:0];
      4'd1:    rd_mux = cha[15:8];
      4'd2:    rd_mux = chb[7:0];
      4'd3:    rd_mux = chb[15:8];
      4'd4:    rd_mux = 8'(div);
      4'd5:    rd_mux = {ie, 5'b0, auto_en, 1'b0};
      4'd6:    rd_mux = {done, 5'b0, pend, state != IDLE};
      default: rd_mux = 8'hAA;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      cha      <= '0;
      chb      <= '0;
      div      <= '0;
      auto_en  <= 1'b0;
      ie       <= 1'b0;
      pend     <= 1'b0;
      done     <= 1'b0;
      cnt      <= '0;
      bcnt     <= '0;
      sha      <= '0;
      shb      <= '0;
      data_out <= '0;
    end else begin
      cha  <= cha_nx;
      chb  <= chb_nx;
      pend <= pend_nx;
      cnt  <= cnt_nx;
      bcnt <= bcnt_nx;
      if (wr && addr == 4'd4) div <= data_in[DIV_W-1:0];
      if (wr && addr == 4'd5) begin
        auto_en <= data_in[1];
        ie      <= data_in[7];
      end
      if (done_set) done <= 1'b1;
      else if (w1c) done <= 1'b0;
      if (load) begin
        sha <= cha_nx[DATA_W-1:0];
        shb <= chb_nx[DATA_W-1:0];
      end else if (shift) begin
        sha <= {sha[DATA_W-2:0], 1'b0};
        shb <= {shb[DATA_W-2:0], 1'b0};
      end
      if (bus_cyc) data_out <= rd_mux;
    end
  end

  assign DAC_clk = (state == SHIFT_HI);
  assign DAC_le  = (state == LATCH);
  assign DAC_d1  = sha[DATA_W-1];
  assign DAC_d2  = shb[DATA_W-1];
  assign irq     = done & ie;

endmodule

// File: tb/tb_dac_serializer.sv
// Scoreboard bench for dac_serializer: a time-based frame model feeds expected bits,
// register reads and irq; a forked negedge monitor compares against the DUT.
module tb_dac_serializer;
  localparam int DW = 16;

  logic       clk_i = 1'b0, rst_n = 1'b0;
  logic [3:0] addr = '0;
  logic [7:0] data_in = '0;
  logic       bus_cyc = 1'b0, bus_we = 1'b0;
  logic [7:0] data_out;
  logic       irq, DAC_clk, DAC_le, DAC_d1, DAC_d2;

  always #5 clk_i = ~clk_i;

  dac_serializer #(.DATA_W(DW), .DIV_W(8)) dut (
    .clk_i(clk_i), .rst_n(rst_n), .addr(addr), .data_in(data_in), .data_out(data_out),
    .bus_cyc(bus_cyc), .bus_we(bus_we), .irq(irq), .DAC_clk(DAC_clk), .DAC_le(DAC_le),
    .DAC_d1(DAC_d1), .DAC_d2(DAC_d2)
  );

  int ncmp = 0, nerr = 0;

  // reference model state
  logic [15:0] m_cha, m_chb;
  logic [7:0]  m_div;
  bit          m_auto, m_ie, m_done, m_pend, m_active, exp_irq;
  int          edge_no, end_edge, fr_div;

  typedef struct packed { logic a; logic b; } bit_t;
  typedef struct { logic [3:0] a; logic [7:0] v; } rd_t;
  bit_t bitq[$];
  rd_t  rdq[$];

  bit prev_clk, prev_le;
  int hi_len, le_len;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cha = '0; m_chb = '0; m_div = '0; m_auto = 0; m_ie = 0; m_done = 0;
    m_pend = 0; m_active = 0; exp_irq = 0; fr_div = 0; end_edge = 0;
    bitq.delete(); rdq.delete();
  endtask

  function automatic logic [7:0] rd_val(input logic [3:0] a);
    case (a)
      4'd0: return m_cha[7:0];
      4'd1: return m_cha[15:8];
      4'd2: return m_chb[7:0];
      4'd3: return m_chb[15:8];
      4'd4: return m_div;
      4'd5: return {m_ie, 5'b0, m_auto, 1'b0};
      4'd6: return {m_done, 5'b0, m_pend, m_active};
      default: return 8'hAA;
    endcase
  endfunction

  // A frame is DW bit periods of two half-periods plus one latch period.
  task automatic start_frame(input int d);
    bit_t e;
    for (int i = DW - 1; i >= 0; i--) begin
      e.a = m_cha[i];
      e.b = m_chb[i];
      bitq.push_back(e);
    end
    fr_div   = d;
    end_edge = edge_no + (2 * DW + 1) * (d + 1);
    m_active = 1;
  endtask

  task automatic model_edge(input bit c, input bit we, input logic [3:0] a, input logic [7:0] d);
    bit trig, w1c, end_now;
    int dold;
    dold = int'(m_div);
    edge_no++;
    if (c) rdq.push_back('{a, rd_val(a)});
    trig = c && we && ((a == 4'd5 && d[0]) || (a == 4'd3 && m_auto));
    w1c  = c && we && a == 4'd6 && d[7];
    if (c && we) begin
      case (a)
        4'd0: m_cha[7:0]  = d;
        4'd1: m_cha[15:8] = d;
        4'd2: m_chb[7:0]  = d;
        4'd3: m_chb[15:8] = d;
        4'd4: m_div = d;
        4'd5: begin m_auto = d[1]; m_ie = d[7]; end
        default: ;
      endcase
    end
    end_now = m_active && edge_no == end_edge;
    m_done  = (m_done && !w1c) || end_now;
    if (end_now) begin
      if (m_pend || trig) begin m_pend = 0; start_frame(dold); end
      else m_active = 0;
    end else if (trig) begin
      if (m_active) m_pend = 1;
      else start_frame(dold);
    end
    exp_irq = m_done && m_ie;
  endtask

  task automatic cyc(input bit c, input bit we, input logic [3:0] a, input logic [7:0] d);
    @(negedge clk_i);
    bus_cyc = c; bus_we = we; addr = a; data_in = d;
    @(posedge clk_i);
    model_edge(c, we, a, d);
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d); cyc(1, 1, a, d); endtask
  task automatic rd(input logic [3:0] a); cyc(1, 0, a, 8'h00); endtask
  task automatic idle(input int n); for (int i = 0; i < n; i++) cyc(0, 0, 4'd0, 8'h00); endtask
  task automatic wr16(input logic [3:0] base, input logic [15:0] v);
    wr(base, v[7:0]);
    wr(base + 4'd1, v[15:8]);
  endtask
  task automatic wait_idle();
    int g = 0;
    while (m_active && g < 5000) begin idle(1); g++; end
    idle(2);
  endtask

  task automatic monitor_step();
    bit_t e;
    rd_t  r;
    if (!rst_n) begin
      prev_clk = 0; prev_le = 0; hi_len = 0; le_len = 0;
    end else begin
      chk("irq", irq, exp_irq);
      if (!m_active) chk("idle_outs", {DAC_clk, DAC_le}, 2'b00);
      if (DAC_clk && !prev_clk) begin
        if (bitq.size() == 0) begin
          ncmp++; nerr++;
          $display("FAIL sclk_rise: got rising edge want none at %0t", $time);
        end else begin
          e = bitq.pop_front();
          chk("d1", DAC_d1, e.a);
          chk("d2", DAC_d2, e.b);
        end
      end
      if (DAC_clk) hi_len++;
      else if (prev_clk) begin chk("sclk_hi_len", hi_len, fr_div + 1); hi_len = 0; end
      if (DAC_le) le_len++;
      else if (prev_le) begin chk("le_len", le_len, fr_div + 1); le_len = 0; end
      if (rdq.size() > 0) begin
        r = rdq.pop_front();
        chk($sformatf("data_out_a%0d", r.a), data_out, r.v);
      end
      prev_clk = DAC_clk;
      prev_le  = DAC_le;
    end
  endtask

  initial begin
    model_reset();
    edge_no = 0;
    fork
      forever begin @(negedge clk_i); monitor_step(); end
    join_none

    repeat (3) @(negedge clk_i);
    chk("rst_outs", {data_out, irq, DAC_clk, DAC_le, DAC_d1, DAC_d2}, 13'h0);
    rst_n = 1'b1;

    // basic frame at minimum divider
    wr(4, 8'h00); wr16(0, 16'hA5C3); wr16(2, 16'h0F0F); wr(5, 8'h01);
    idle(5); rd(6); idle(25); rd(6); rd(6); rd(6); rd(6);
    wait_idle(); rd(6); wr(6, 8'h80);

    // AUTO trigger, slow divider, mid-frame restage + GO collapses into PEND
    wr(4, 8'h03); wr(5, 8'h02); wr16(0, 16'h8001); wr(2, 8'h34); wr(3, 8'h12);
    idle(40); wr16(0, 16'hFFFF); wr(5, 8'h03); wr(5, 8'h03); rd(6);
    wait_idle(); wr(5, 8'h00);

    // interrupt enable / W1C / disable
    wr(5, 8'h80); idle(2); wr(6, 8'h80); idle(2);
    wr(4, 8'h00); wr(5, 8'h81); wait_idle(); idle(2);
    wr(5, 8'h00); idle(2); wr(5, 8'h80); idle(1);

    // async reset mid-frame (around bit 7), DONE & IE still set so irq is high
    wr(5, 8'h81); idle(15);
    #2 rst_n = 1'b0;
    #1 chk("rst_async", {irq, DAC_clk, DAC_le, DAC_d1, DAC_d2}, 5'h0);
    model_reset();
    repeat (2) @(negedge clk_i);
    rst_n = 1'b1;
    rd(6); rd(4); rd(0); rd(12); idle(2);
    wr(5, 8'h01); idle(3); rd(6); wait_idle();

    // randomized frames
    for (int k = 0; k < 8; k++) begin
      logic [7:0]  dv;
      logic [15:0] va, vb;
      bit          ie_r;
      wait_idle();
      dv = 8'($urandom_range(0, 3)); va = 16'($urandom); vb = 16'($urandom);
      ie_r = 1'($urandom_range(0, 1));
      wr(4, dv); wr16(0, va); wr(2, vb[7:0]);
      if (k % 2 == 1) begin wr(5, {ie_r, 5'b0, 1'b1, 1'b0}); wr(3, vb[15:8]); end
      else begin wr(3, vb[15:8]); wr(5, {ie_r, 5'b0, 1'b0, 1'b1}); end
      if (k == 5) begin
        while (m_active && edge_no + 1 < end_edge) idle(1);
        wr(5, 8'h01);
      end else begin
        for (int j = 0; j < 12; j++) begin
          case ($urandom_range(0, 5))
            0: rd(4'($urandom_range(0, 15)));
            1: wr(4'($urandom_range(7, 15)), 8'($urandom));
            2: wr(6, 8'h80);
            3: wr16(2, 16'($urandom));
            4: wr(5, {ie_r, 5'b0, 1'b0, 1'b1});
            default: idle($urandom_range(1, 10));
          endcase
        end
      end
    end
    wait_idle();
    rd(12); idle(2);
    chk("bitq_empty", bitq.size(), 0);
    chk("rdq_empty", rdq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
